// File: rtl/wb_master_pkg.sv
// Shared state encoding, Wishbone cycle/burst type codes and completion
// status codes for the Wishbone burst master.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUS     = 2'b01,
    BACKOFF = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and a slave.
interface wb_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [2:0]        wb_cti_o;
  logic [1:0]        wb_bte_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;
  logic              wb_err_i;
  logic              wb_rty_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_beat_counter.sv
// Current beat address and beats still to issue for the active command;
// a retry leaves both untouched so the bus resumes where it stopped.
module wb_beat_counter #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_adr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              advance,
  output logic [ADDR_W-1:0] adr,
  output logic              last
);

  logic [ADDR_W-1:0] adr_r;
  logic [LEN_W-1:0]  rem_r;

  // Load on command accept, step one word on each acknowledged beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_r <= '0;
      rem_r <= '0;
    end else if (load) begin
      adr_r <= load_adr & {{(ADDR_W-2){1'b1}}, 2'b00};
      rem_r <= load_len;
    end else if (advance) begin
      adr_r <= adr_r + ADDR_W'(4);
      rem_r <= rem_r - LEN_W'(1);
    end
  end

  assign adr  = adr_r;
  assign last = (rem_r == '0);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 initiator issuing single or incrementing-burst cycles, with
// ERR abort, bounded RTY back-off and a no-response timeout.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int RTY_LIMIT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [ADDR_W-1:0]          cmd_adr,
  input  logic [$clog2(MAX_BURST)-1:0] cmd_len,
  input  logic [DATA_W/8-1:0]        cmd_sel,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_last,
  output logic                       done_valid,
  output logic [1:0]                 done_status,
  output logic [$clog2(MAX_BURST):0] done_beats,
  wb_burst_master_if.master          wb
);

  localparam int LEN_W = $clog2(MAX_BURST);
  localparam int CNT_W = LEN_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(RTY_LIMIT + 1);

  state_t              state_r;
  logic                cyc_r;
  logic                cmd_ready_r;
  logic                we_r;
  logic                single_r;
  logic                backoff_r;
  logic [DATA_W/8-1:0] sel_r;
  logic [CNT_W-1:0]    ack_cnt_r;
  logic [RTY_W-1:0]    rty_cnt_r;
  logic [TMO_W-1:0]    tmo_cnt_r;
  logic                rd_valid_r;
  logic                rd_last_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic                done_valid_r;
  logic [1:0]          done_status_r;
  logic [CNT_W-1:0]    done_beats_r;

  logic [ADDR_W-1:0]   adr_s;
  logic                last_s;
  logic                accept_s;
  logic                stb_s;
  logic                err_s;
  logic                rty_s;
  logic                ack_s;
  logic [2:0]          cti_s;

  assign accept_s = (state_r == IDLE) && cmd_valid && cmd_ready_r;
  // A write beat with no data available holds STB low inside the cycle.
  assign stb_s    = cyc_r && (!we_r || wr_valid);
  assign err_s    = stb_s && wb.wb_err_i;
  assign rty_s    = stb_s && !wb.wb_err_i && wb.wb_rty_i;
  assign ack_s    = stb_s && !wb.wb_err_i && !wb.wb_rty_i && wb.wb_ack_i;

  wb_beat_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_beat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_s),
    .load_adr (cmd_adr),
    .load_len (cmd_len),
    .advance  (ack_s),
    .adr      (adr_s),
    .last     (last_s)
  );

  // Cycle type follows the beats still remaining, so it is correct after a retry.
  always_comb begin
    cti_s = CTI_CLASSIC;
    if (!cyc_r || single_r) begin
      cti_s = CTI_CLASSIC;
    end else if (last_s) begin
      cti_s = CTI_EOB;
    end else begin
      cti_s = CTI_INCR;
    end
  end

  // Command FSM with response handling and registered user-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cyc_r         <= 1'b0;
      cmd_ready_r   <= 1'b0;
      we_r          <= 1'b0;
      single_r      <= 1'b0;
      backoff_r     <= 1'b0;
      sel_r         <= '0;
      ack_cnt_r     <= '0;
      rty_cnt_r     <= '0;
      tmo_cnt_r     <= '0;
      rd_valid_r    <= 1'b0;
      rd_last_r     <= 1'b0;
      rd_data_r     <= '0;
      done_valid_r  <= 1'b0;
      done_status_r <= 2'b00;
      done_beats_r  <= '0;
    end else begin
      rd_valid_r   <= 1'b0;
      rd_last_r    <= 1'b0;
      done_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cmd_ready_r <= 1'b1;
          if (accept_s) begin
            we_r        <= cmd_we;
            sel_r       <= cmd_sel;
            single_r    <= (cmd_len == '0);
            ack_cnt_r   <= '0;
            rty_cnt_r   <= '0;
            tmo_cnt_r   <= '0;
            cmd_ready_r <= 1'b0;
            cyc_r       <= 1'b1;
            state_r     <= BUS;
          end
        end
        BUS: begin
          if (err_s) begin
            cyc_r         <= 1'b0;
            done_valid_r  <= 1'b1;
            done_status_r <= ST_ERR;
            done_beats_r  <= ack_cnt_r;
            state_r       <= DONE;
          end else if (rty_s) begin
            tmo_cnt_r <= '0;
            cyc_r     <= 1'b0;
            if (rty_cnt_r == RTY_W'(RTY_LIMIT - 1)) begin
              done_valid_r  <= 1'b1;
              done_status_r <= ST_RTY;
              done_beats_r  <= ack_cnt_r;
              state_r       <= DONE;
            end else begin
              rty_cnt_r <= rty_cnt_r + RTY_W'(1);
              backoff_r <= 1'b0;
              state_r   <= BACKOFF;
            end
          end else if (ack_s) begin
            tmo_cnt_r <= '0;
            ack_cnt_r <= ack_cnt_r + CNT_W'(1);
            if (!we_r) begin
              rd_valid_r <= 1'b1;
              rd_data_r  <= wb.wb_dat_i;
              rd_last_r  <= last_s;
            end
            if (last_s) begin
              cyc_r         <= 1'b0;
              done_valid_r  <= 1'b1;
              done_status_r <= ST_OK;
              done_beats_r  <= ack_cnt_r + CNT_W'(1);
              state_r       <= DONE;
            end
          end else if (stb_s) begin
            if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
              cyc_r         <= 1'b0;
              done_valid_r  <= 1'b1;
              done_status_r <= ST_TMO;
              done_beats_r  <= ack_cnt_r;
              state_r       <= DONE;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
          end
        end
        BACKOFF: begin
          if (backoff_r) begin
            cyc_r   <= 1'b1;
            state_r <= BUS;
          end else begin
            backoff_r <= 1'b1;
          end
        end
        DONE: begin
          cmd_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          cyc_r       <= 1'b0;
          cmd_ready_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign wr_ready    = ack_s && we_r;
  assign rd_valid    = rd_valid_r;
  assign rd_data     = rd_data_r;
  assign rd_last     = rd_last_r;
  assign done_valid  = done_valid_r;
  assign done_status = done_status_r;
  assign done_beats  = done_beats_r;

  assign wb.wb_cyc_o = cyc_r;
  assign wb.wb_stb_o = stb_s;
  assign wb.wb_we_o  = we_r;
  assign wb.wb_adr_o = adr_s;
  assign wb.wb_sel_o = sel_r;
  assign wb.wb_dat_o = (cyc_r && we_r) ? wr_data : '0;
  assign wb.wb_cti_o = cti_s;
  assign wb.wb_bte_o = BTE_LINEAR;

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized bench for wb_burst_master: a scripted Wishbone slave plus a
// transaction-level model of addresses, cycle types, data and completion.
module tb_wb_burst_master;
  import wb_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [2:0]  cmd_len;
  logic [3:0]  cmd_sel;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        done_valid;
  logic [1:0]  done_status;
  logic [3:0]  done_beats;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_rd;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  always #5 clk = ~clk;

  wb_burst_master_if #(.ADDR_W(32), .DATA_W(32)) wb ();

  wb_burst_master dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_adr     (cmd_adr),
    .cmd_len     (cmd_len),
    .cmd_sel     (cmd_sel),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .done_valid  (done_valid),
    .done_status (done_status),
    .done_beats  (done_beats),
    .wb          (wb)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    if (slave_mem.exists(a)) return slave_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic check_reset_state();
    check_eq("rst_cyc", 64'(wb.wb_cyc_o), 64'd0);
    check_eq("rst_stb", 64'(wb.wb_stb_o), 64'd0);
    check_eq("rst_we", 64'(wb.wb_we_o), 64'd0);
    check_eq("rst_adr", 64'(wb.wb_adr_o), 64'd0);
    check_eq("rst_sel", 64'(wb.wb_sel_o), 64'd0);
    check_eq("rst_dat", 64'(wb.wb_dat_o), 64'd0);
    check_eq("rst_cti", 64'(wb.wb_cti_o), 64'd0);
    check_eq("rst_bte", 64'(wb.wb_bte_o), 64'd0);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_wr_ready", 64'(wr_ready), 64'd0);
    check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_rd_last", 64'(rd_last), 64'd0);
    check_eq("rst_rd_data", 64'(rd_data), 64'd0);
    check_eq("rst_done_valid", 64'(done_valid), 64'd0);
    check_eq("rst_done_status", 64'(done_status), 64'd0);
    check_eq("rst_done_beats", 64'(done_beats), 64'd0);
  endtask

  // mode 0: ACK (wait_pct % no-response); 1: ERR at beat pa; 2: pb RTYs at beat pa; 3: silent.
  // stall_beat >= 0: hold wr_valid low stall_n cycles at that beat; -1 none; -2 random.
  task automatic run_cmd(input logic we, input logic [31:0] adr, input int len, input logic [3:0] sel,
                         input int mode, input int pa, input int pb, input int wait_pct,
                         input logic [31:0] wd0, input int stall_beat, input int stall_n);
    logic [31:0] wd [8];
    logic [31:0] base, eadr;
    logic [2:0]  ecti;
    logic [1:0]  est;
    int acks, rtys, tmo, back, stalled, rty_left, r;
    bit fin, exp_done, exp_rd_v, exp_rd_last;
    logic [31:0] exp_rd_data;
    base = adr & 32'hFFFF_FFFC;
    for (int i = 0; i < 8; i++) wd[i] = (i == 0) ? wd0 : $urandom;
    acks = 0; rtys = 0; tmo = 0; back = 0; stalled = 0; rty_left = pb;
    fin = 1'b0; exp_done = 1'b0; exp_rd_v = 1'b0; exp_rd_last = 1'b0; exp_rd_data = 32'd0; est = ST_OK;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = 3'(len); cmd_sel = sel;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    check_eq("cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_adr = $urandom; cmd_we = ~we; cmd_len = 3'($urandom); cmd_sel = 4'($urandom);

    for (int c = 0; c < 1500 && !fin; c++) begin
      @(negedge clk);
      wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
      check_eq("rd_valid", 64'(rd_valid), 64'(exp_rd_v));
      if (exp_rd_v) begin
        check_eq("rd_data", 64'(rd_data), 64'(exp_rd_data));
        check_eq("rd_last", 64'(rd_last), 64'(exp_rd_last));
        last_rd = rd_data;
        exp_rd_v = 1'b0;
      end
      if (exp_done) begin
        check_eq("done_cyc", 64'(wb.wb_cyc_o), 64'd0);
        check_eq("done_valid", 64'(done_valid), 64'd1);
        check_eq("done_status", 64'(done_status), 64'(est));
        check_eq("done_beats", 64'(done_beats), 64'(acks));
        fin = 1'b1;
      end else begin
        check_eq("no_done", 64'(done_valid), 64'd0);
        if (back > 0) begin
          check_eq("backoff_cyc", 64'(wb.wb_cyc_o), 64'd0);
          back--;
        end else begin
          check_eq("bus_cyc", 64'(wb.wb_cyc_o), 64'd1);
          if (!we) wr_valid = 1'($urandom_range(0, 1));
          else if (stall_beat >= 0) begin
            wr_valid = !(acks == stall_beat && stalled < stall_n);
            if (!wr_valid) stalled++;
          end else if (stall_beat == -2) wr_valid = ($urandom_range(0, 4) != 0);
          else wr_valid = 1'b1;
          wr_data = wr_valid ? wd[acks] : $urandom;
          #1;
          check_eq("stb", 64'(wb.wb_stb_o), 64'(!we || wr_valid));
          if (!we || wr_valid) begin
            eadr = base + 32'(4 * acks);
            ecti = (len == 0) ? CTI_CLASSIC : ((acks == len) ? CTI_EOB : CTI_INCR);
            check_eq("adr", 64'(wb.wb_adr_o), 64'(eadr));
            check_eq("cti", 64'(wb.wb_cti_o), 64'(ecti));
            check_eq("bte", 64'(wb.wb_bte_o), 64'(BTE_LINEAR));
            check_eq("we", 64'(wb.wb_we_o), 64'(we));
            check_eq("sel", 64'(wb.wb_sel_o), 64'(sel));
            if (we) check_eq("dat_o", 64'(wb.wb_dat_o), 64'(wd[acks]));
            r = ($urandom_range(0, 99) < wait_pct) ? 0 : 1;
            if (mode == 1 && acks == pa) r = 2;
            if (mode == 2 && acks == pa && rty_left > 0) begin r = 3; rty_left--; end
            if (mode == 3) r = 0;
            wb.wb_err_i = (r == 2);
            wb.wb_rty_i = (r == 3) || (r == 2 && $urandom_range(0, 1) == 1);
            wb.wb_ack_i = (r == 1) || (r >= 2 && $urandom_range(0, 1) == 1);
            wb.wb_dat_i = slave_rd(wb.wb_adr_o);
            #1;
            check_eq("wr_ready", 64'(wr_ready), 64'(we && r == 1));
            case (r)
              0: begin
                tmo++;
                if (tmo == 255) begin exp_done = 1'b1; est = ST_TMO; end
              end
              1: begin
                tmo = 0;
                if (we) begin
                  model_mem[eadr] = merge(model_rd(eadr), wd[acks], sel);
                  slave_mem[wb.wb_adr_o] = merge(slave_rd(wb.wb_adr_o), wb.wb_dat_o, wb.wb_sel_o);
                end else begin
                  exp_rd_v = 1'b1; exp_rd_data = model_rd(eadr); exp_rd_last = (acks == len);
                end
                acks++;
                if (acks == len + 1) begin exp_done = 1'b1; est = ST_OK; end
              end
              2: begin exp_done = 1'b1; est = ST_ERR; end
              default: begin
                tmo = 0; rtys++;
                if (rtys == 4) begin exp_done = 1'b1; est = ST_RTY; end
                else back = 2;
              end
            endcase
          end
        end
      end
    end
    if (!fin) check_eq("cmd_finished", 64'd0, 64'd1);
    @(negedge clk);
    wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
    check_eq("post_done_valid", 64'(done_valid), 64'd0);
    check_eq("post_cyc", 64'(wb.wb_cyc_o), 64'd0);
    check_eq("post_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int m, ln;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'd0; cmd_len = 3'd0; cmd_sel = 4'd0;
    wr_valid = 1'b0; wr_data = 32'd0; last_rd = 32'd0;
    wb.wb_dat_i = 32'd0; wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;

    run_cmd(1'b1, 32'h100, 0, 4'hF, 0, 0, 0, 0, 32'hDEAD_BEEF, -1, 0);
    run_cmd(1'b0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 32'd0, -1, 0);
    check_eq("readback_0x100", 64'(last_rd), 64'h0000_0000_DEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      model_mem[32'h200 + 32'(4 * i)] = 32'(8'h11 * (i + 1));
      slave_mem[32'h200 + 32'(4 * i)] = 32'(8'h11 * (i + 1));
    end
    run_cmd(1'b0, 32'h200, 3, 4'hF, 0, 0, 0, 0, 32'd0, -1, 0);
    check_eq("burst_last_data", 64'(last_rd), 64'h44);
    run_cmd(1'b1, 32'h300, 3, 4'hF, 0, 0, 0, 0, 32'hCAFE_0001, 2, 3);
    run_cmd(1'b0, 32'h400, 3, 4'hF, 1, 1, 0, 0, 32'd0, -1, 0);
    run_cmd(1'b0, 32'h500, 1, 4'hF, 2, 1, 1, 0, 32'd0, -1, 0);
    run_cmd(1'b0, 32'h600, 1, 4'hF, 2, 0, 4, 0, 32'd0, -1, 0);
    run_cmd(1'b0, 32'h700, 0, 4'hF, 3, 0, 0, 0, 32'd0, -1, 0);
    run_cmd(1'b1, 32'hFFFF_FFF9, 3, 4'h5, 0, 0, 0, 30, 32'h1234_5678, -2, 0);
    run_cmd(1'b0, 32'hFFFF_FFF8, 3, 4'hF, 0, 0, 0, 0, 32'd0, -1, 0);
    run_cmd(1'b1, 32'h800, 2, 4'hF, 3, 0, 0, 0, 32'd0, -2, 0);

    for (int t = 0; t < 60; t++) begin
      m  = $urandom_range(0, 9);
      m  = (m < 6) ? 0 : ((m < 8) ? 1 : 2);
      ln = $urandom_range(0, 7);
      run_cmd(1'($urandom_range(0, 1)), {20'd0, 12'($urandom)}, ln, 4'($urandom), m,
              $urandom_range(0, ln), $urandom_range(1, 5), 25, $urandom, -2, 0);
    end

    // Reset in the middle of a burst that the slave never answers.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h900; cmd_len = 3'd3; cmd_sel = 4'hF;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst_cyc_before", 64'(wb.wb_cyc_o), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("midrst_cyc_async", 64'(wb.wb_cyc_o), 64'd0);
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("midrst_no_done", 64'(done_valid), 64'd0);
      check_eq("midrst_idle_cyc", 64'(wb.wb_cyc_o), 64'd0);
    end
    run_cmd(1'b0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 32'd0, -1, 0);
    check_eq("after_rst_readback", 64'(last_rd), 64'h0000_0000_DEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
